rec_play_ctrl: RTL and testbench
================================

# rec_play_ctrl

Sequencing controller for the audio record/playback path. Converts debounced record/play button levels into a four-state schedule. Drives the 32-bit bit counter, the 937-entry packet counter, the packet-memory write/read strobes and the prepacket flag. Sits between the button debouncers and the serializer/shift-register datapath and the packet RAM.

## Interface
- PKT_BITS, 32, bits per packet; bit counter width is $clog2(PKT_BITS).
- NUM_PKTS, 937, packets per recording; last index is NUM_PKTS-1.
- ADDR_W, 10, packet counter and RAM address width; must satisfy 2^ADDR_W >= NUM_PKTS.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rec_btn  in  1  debounced record button level.
- play_btn  in  1  debounced play button level.
- bit_tick  in  1  one-cycle strobe per serial bit period.
- bit_cnt  out  5  index of current bit in packet, 0..31.
- pkt_cnt  out  ADDR_W  current packet index, 0..NUM_PKTS-1.
- mem_we  out  1  one-cycle write strobe; write address is mem_addr.
- mem_re  out  1  one-cycle read strobe; read address is mem_addr.
- mem_addr  out  ADDR_W  RAM address for mem_we/mem_re.
- prepacket  out  1  high for the whole PRE state.
- busy  out  1  high whenever state is not IDLE.
- rec_valid  out  1  memory holds a complete recording.
- done  out  1  one-cycle pulse when a record or play pass completes.

## Operation
- All outputs are registered. Reset value of every output is 0. Reset forces state IDLE.
- Buttons are rising-edge detected internally by one register each. Only press events (0→1) act; held levels are ignored.
- States:
  - IDLE: no activity.
  - REC: recording packets into memory.
  - PRE: one fetch packet before playback; prepacket=1 for its full duration.
  - PLAY: playing packets from memory.
- Transitions on press events:
  - rec press in any state → REC. bit_cnt=0, pkt_cnt=0, rec_valid=0. An aborted recording leaves rec_valid=0.
  - play press in IDLE with rec_valid=1 → PRE. With rec_valid=0 the press is ignored.
  - play press in PRE or PLAY → PRE (restart), unless LOOP_PLAY_EN is defined.
  - play press in REC is ignored.
  - Simultaneous rec and play press: rec wins.
- bit_cnt counts bit_tick events, 0..PKT_BITS-1, and wraps to 0. It holds in IDLE.
- REC:
  - On bit_tick with bit_cnt==31: mem_we=1 next cycle, with mem_addr equal to the pre-increment pkt_cnt. pkt_cnt then increments.
  - On bit_tick with bit_cnt==31 and pkt_cnt==NUM_PKTS-1: last write issued, pkt_cnt→0, rec_valid→1, done pulse, → IDLE.
- PRE:
  - On entry: mem_re=1 with mem_addr=0 (one cycle), bit_cnt=0, pkt_cnt=0.
  - On bit_tick with bit_cnt==31: → PLAY, pkt_cnt stays 0, prepacket drops.
- PLAY:
  - On bit_tick with bit_cnt==31 and pkt_cnt<NUM_PKTS-1: mem_re=1 next cycle with mem_addr=pkt_cnt+1, and pkt_cnt increments.
  - At pkt_cnt==NUM_PKTS-1, bit 31: done pulse, pkt_cnt→0, → IDLE (see Configuration).
- Arithmetic: pkt_cnt compares use exact equality to NUM_PKTS-1 and never exceed it. bit_cnt wraps naturally at 31.

## Timing
- Press-to-state latency: 2 cycles (edge register + state register). The counter clear lands in the same cycle as the state change.
- mem_we and mem_re are asserted 1 cycle after the qualifying bit_tick, so the datapath shift register already holds bit 31. The RAM returns read data 1 cycle after mem_re.
- PRE lasts exactly PKT_BITS bit_ticks. Total playback is NUM_PKTS+1 packet periods.
- bit_tick arriving in the same cycle as a press event is discarded; the restart takes priority.
- Reset mid-operation clears everything, including rec_valid, with no trailing strobes.

## Configuration
- LOOP_PLAY_EN defined:
  - After the last PLAY packet, the block goes → PRE (re-fetch address 0), with done pulsing each pass.
  - A play press in PRE or PLAY stops playback → IDLE.
- LOOP_PLAY_EN undefined:
  - Playback ends in IDLE after one pass.
  - A play press in PRE or PLAY restarts at PRE.

## Structure
- A shared package `rec_play_pkg` holds:
  - the state enum (IDLE, REC, PRE, PLAY);
  - PKT_BITS and NUM_PKTS defaults;
  - the LAST_PKT and LAST_BIT constants.
- One sub-module, `btn_edge`: press-edge detector instantiated twice.
- FSM and counters stay in the top module.

## Test plan
- Reset, then 40 bit_ticks with no press → all outputs 0, state IDLE, no strobes.
- rec press, then 937×32 bit_ticks:
  - 937 mem_we pulses, addresses 0..936 in order;
  - after the last pulse: done=1 for one cycle, rec_valid=1, busy=0.
- After a full record, play press:
  - mem_re at address 0 on PRE entry; prepacket high for 32 ticks;
  - then mem_re at addresses 1..936;
  - done after 938 packet periods, → IDLE.
- play press with rec_valid=0 → stays IDLE, no mem_re.
- rec press at packet 500 of PLAY → REC, pkt_cnt=0, bit_cnt=0, rec_valid=0, first mem_we at address 0.
- rec and play pressed in the same cycle from IDLE → REC. With LOOP_PLAY_EN, a full play pass re-enters PRE with mem_re at address 0, and a second play press → IDLE.

Source files
------------

// File: rtl/rec_play_pkg.sv
// Shared types and sizing for the record/playback sequencer.
// Holds the state enum, packet geometry and the last-bit/last-packet constants.
package rec_play_pkg;

    localparam int PKT_BITS = 32;
    localparam int NUM_PKTS = 937;
    localparam int ADDR_W   = 10;
    localparam int BIT_W    = $clog2(PKT_BITS);

    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(PKT_BITS - 1);
    localparam logic [ADDR_W-1:0] LAST_PKT = ADDR_W'(NUM_PKTS - 1);

    typedef enum logic [1:0] {
        IDLE,
        REC,
        PRE,
        PLAY
    } state_t;

endpackage

// File: rtl/rec_play_ctrl_if.sv
// Bundle between buttons/bit timer and the sequencer, plus its counter/strobe outputs.
// master: sequencer side (drives counters, strobes, flags); slave: surrounding datapath.
interface rec_play_ctrl_if
    import rec_play_pkg::*;
();

    logic              rec_btn;
    logic              play_btn;
    logic              bit_tick;
    logic [BIT_W-1:0]  bit_cnt;
    logic [ADDR_W-1:0] pkt_cnt;
    logic              mem_we;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic              prepacket;
    logic              busy;
    logic              rec_valid;
    logic              done;

    modport master (
        input  rec_btn, play_btn, bit_tick,
        output bit_cnt, pkt_cnt, mem_we, mem_re, mem_addr,
        output prepacket, busy, rec_valid, done
    );

    modport slave (
        output rec_btn, play_btn, bit_tick,
        input  bit_cnt, pkt_cnt, mem_we, mem_re, mem_addr,
        input  prepacket, busy, rec_valid, done
    );

endinterface

// File: rtl/rec_play_ctrl_btn_edge.sv
// Press detector: registered one-cycle pulse on a 0->1 button level change.
// Ports: clk, reset (async, high), btn (level in), press (pulse out).
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    logic btn_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_q <= 1'b0;
            press <= 1'b0;
        end else begin
            btn_q <= btn;
            press <= btn & ~btn_q;
        end
    end

endmodule

// File: rtl/rec_play_ctrl.sv
// Record/playback sequencer: IDLE/REC/PRE/PLAY schedule, bit and packet counters, RAM strobes.
// Ports: clk, reset (async, high), bus (rec_play_ctrl_if.master). Macro: LOOP_PLAY_EN.
module rec_play_ctrl
    import rec_play_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    rec_play_ctrl_if.master bus
);

    state_t            state;
    state_t            state_n;
    logic              rec_press;
    logic              play_press;
    logic              play_act;
    logic              go_pre;
    logic [BIT_W-1:0]  bit_n;
    logic [ADDR_W-1:0] pkt_n;
    logic [ADDR_W-1:0] addr_n;
    logic              we_n;
    logic              re_n;
    logic              valid_n;
    logic              done_n;

    btn_edge u_rec_edge (
        .clk   (clk),
        .reset (reset),
        .btn   (bus.rec_btn),
        .press (rec_press)
    );

    btn_edge u_play_edge (
        .clk   (clk),
        .reset (reset),
        .btn   (bus.play_btn),
        .press (play_press)
    );

    always_comb begin
        state_n  = state;
        bit_n    = bus.bit_cnt;
        pkt_n    = bus.pkt_cnt;
        addr_n   = bus.mem_addr;
        we_n     = 1'b0;
        re_n     = 1'b0;
        valid_n  = bus.rec_valid;
        done_n   = 1'b0;
        go_pre   = 1'b0;
        // play is ignored while recording or with nothing recorded
        play_act = play_press && (state != REC) &&
                   ((state != IDLE) || bus.rec_valid);

        // presses take priority; a bit_tick in a press cycle is dropped
        if (rec_press) begin
            state_n = REC;
            bit_n   = '0;
            pkt_n   = '0;
            valid_n = 1'b0;
        end else if (play_act) begin
`ifdef LOOP_PLAY_EN
            if (state == IDLE) begin
                go_pre = 1'b1;
            end else begin
                state_n = IDLE;
                bit_n   = '0;
                pkt_n   = '0;
            end
`else
            go_pre = 1'b1;
`endif
        end else if (bus.bit_tick && (state != IDLE)) begin
            bit_n = bus.bit_cnt + 1'b1;
            if (bus.bit_cnt == LAST_BIT) begin
                bit_n = '0;
                unique case (state)
                    REC: begin
                        we_n   = 1'b1;
                        addr_n = bus.pkt_cnt;
                        if (bus.pkt_cnt == LAST_PKT) begin
                            pkt_n   = '0;
                            valid_n = 1'b1;
                            done_n  = 1'b1;
                            state_n = IDLE;
                        end else begin
                            pkt_n = bus.pkt_cnt + 1'b1;
                        end
                    end
                    PRE: begin
                        state_n = PLAY;
                        pkt_n   = '0;
                    end
                    PLAY: begin
                        if (bus.pkt_cnt == LAST_PKT) begin
                            done_n = 1'b1;
                            pkt_n  = '0;
`ifdef LOOP_PLAY_EN
                            go_pre = 1'b1;
`else
                            state_n = IDLE;
`endif
                        end else begin
                            re_n   = 1'b1;
                            addr_n = bus.pkt_cnt + 1'b1;
                            pkt_n  = bus.pkt_cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end

        // PRE entry always fetches packet 0 ahead of playback
        if (go_pre) begin
            state_n = PRE;
            bit_n   = '0;
            pkt_n   = '0;
            re_n    = 1'b1;
            addr_n  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            bus.bit_cnt   <= '0;
            bus.pkt_cnt   <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_re    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.prepacket <= 1'b0;
            bus.busy      <= 1'b0;
            bus.rec_valid <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            state         <= state_n;
            bus.bit_cnt   <= bit_n;
            bus.pkt_cnt   <= pkt_n;
            bus.mem_we    <= we_n;
            bus.mem_re    <= re_n;
            bus.mem_addr  <= addr_n;
            bus.prepacket <= (state_n == PRE);
            bus.busy      <= (state_n != IDLE);
            bus.rec_valid <= valid_n;
            bus.done      <= done_n;
        end
    end

endmodule

// File: tb/tb_rec_play_ctrl.sv
// Self-checking bench for rec_play_ctrl: randomized tick gaps against a counting model.
// Covers reset, ignored play, simultaneous press, full record, full play, abort and async reset.
module tb_rec_play_ctrl;

    localparam int NT  = 937 * 32;
    localparam int NTP = 938 * 32;

    typedef struct packed {
        logic [4:0] bc;
        logic [9:0] pc;
        logic       we;
        logic       re;
        logic [9:0] addr;
        logic       pre;
        logic       busy;
        logic       rv;
        logic       done;
    } snap_t;

    logic  clk = 1'b0;
    logic  reset;
    int    checks = 0;
    int    errors = 0;
    snap_t e;

    rec_play_ctrl_if bus ();

    rec_play_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic snap_t snap();
        snap_t s;
        s.bc   = bus.bit_cnt;
        s.pc   = bus.pkt_cnt;
        s.we   = bus.mem_we;
        s.re   = bus.mem_re;
        s.addr = (bus.mem_we || bus.mem_re) ? bus.mem_addr : 10'd0;
        s.pre  = bus.prepacket;
        s.busy = bus.busy;
        s.rv   = bus.rec_valid;
        s.done = bus.done;
        return s;
    endfunction

    function automatic string fmt(snap_t s);
        return $sformatf("bc=%0d pc=%0d we=%0b re=%0b addr=%0d pre=%0b busy=%0b rv=%0b done=%0b",
                         s.bc, s.pc, s.we, s.re, s.addr, s.pre, s.busy, s.rv, s.done);
    endfunction

    // model: state after the n-th tick of a recording pass
    function automatic snap_t rec_exp(int n);
        snap_t r = '0;
        r.busy = 1'b1;
        r.bc   = 5'(n % 32);
        r.pc   = 10'(n / 32);
        if (n % 32 == 0) begin
            r.we   = 1'b1;
            r.addr = 10'(n / 32 - 1);
        end
        if (n == NT) begin
            r.pc   = '0;
            r.busy = 1'b0;
            r.rv   = 1'b1;
            r.done = 1'b1;
        end
        return r;
    endfunction

    // model: state after the n-th tick since PRE entry
    function automatic snap_t play_exp(int n);
        snap_t r = '0;
        r.rv   = 1'b1;
        r.busy = 1'b1;
        r.bc   = 5'(n % 32);
        r.pre  = (n < 32);
        if (n >= 32) r.pc = 10'(n / 32 - 1);
        if (n >= 64 && n % 32 == 0) begin
            r.re   = 1'b1;
            r.addr = 10'(n / 32 - 1);
        end
        if (n == NTP) begin
`ifdef LOOP_PLAY_EN
            r.pc   = '0;
            r.pre  = 1'b1;
            r.re   = 1'b1;
            r.addr = '0;
            r.done = 1'b1;
`else
            r      = '0;
            r.rv   = 1'b1;
            r.done = 1'b1;
`endif
        end
        return r;
    endfunction

    task automatic step(input logic t);
        bus.bit_tick = t;
        @(negedge clk);
    endtask

    task automatic press(input logic r, input logic p, input logic t);
        bus.rec_btn  = r;
        bus.play_btn = p;
        bus.bit_tick = t;
        @(negedge clk);
        bus.rec_btn  = 1'b0;
        bus.play_btn = 1'b0;
        @(negedge clk);
        bus.bit_tick = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        reset        = 1'b1;
        bus.rec_btn  = 1'b0;
        bus.play_btn = 1'b0;
        bus.bit_tick = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (snap() !== snap_t'('0)) begin
            errors++;
            $display("FAIL reset_state got %s want all 0", fmt(snap()));
        end
        reset = 1'b0;
        n = 0;
        while (n < 40) begin
            if ($urandom_range(3) == 0) step(1'b0);
            else begin
                step(1'b1);
                n++;
            end
            checks++;
            if (snap() !== snap_t'('0)) begin
                errors++;
                $display("FAIL idle_ticks n=%0d got %s want all 0", n, fmt(snap()));
            end
        end
    endtask

    task automatic test_play_no_rec();
        press(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(1'($urandom_range(1)));
            checks++;
            if (snap() !== snap_t'('0)) begin
                errors++;
                $display("FAIL play_no_rec i=%0d got %s want all 0", i, fmt(snap()));
            end
        end
    endtask

    task automatic test_simul_press();
        int nt;
        press(1'b1, 1'b1, 1'b0);
        e      = '0;
        e.busy = 1'b1;
        checks++;
        if (snap() !== e) begin
            errors++;
            $display("FAIL simul_press got %s want %s", fmt(snap()), fmt(e));
        end
        nt = $urandom_range(3, 20);
        for (int i = 1; i <= nt; i++) begin
            step(1'b1);
            e.bc = 5'(i);
            checks++;
            if (snap() !== e) begin
                errors++;
                $display("FAIL simul_ticks i=%0d got %s want %s", i, fmt(snap()), fmt(e));
            end
        end
        press(1'b0, 1'b1, 1'b0);
        checks++;
        if (snap() !== e) begin
            errors++;
            $display("FAIL play_in_rec got %s want %s", fmt(snap()), fmt(e));
        end
    endtask

    task automatic test_record();
        int n;
        press(1'b1, 1'b0, 1'b0);
        e      = '0;
        e.busy = 1'b1;
        checks++;
        if (snap() !== e) begin
            errors++;
            $display("FAIL rec_start got %s want %s", fmt(snap()), fmt(e));
        end
        n = 0;
        while (n < NT) begin
            if ($urandom_range(31) == 0) step(1'b0);
            else begin
                step(1'b1);
                n++;
                e = rec_exp(n);
                checks++;
                if (snap() !== e) begin
                    errors++;
                    $display("FAIL record n=%0d got %s want %s", n, fmt(snap()), fmt(e));
                end
            end
        end
        step(1'b0);
        e    = '0;
        e.rv = 1'b1;
        checks++;
        if (snap() !== e) begin
            errors++;
            $display("FAIL rec_end got %s want %s", fmt(snap()), fmt(e));
        end
    endtask

    task automatic test_play();
        int n;
        press(1'b0, 1'b1, 1'b0);
        e      = '0;
        e.rv   = 1'b1;
        e.busy = 1'b1;
        e.pre  = 1'b1;
        e.re   = 1'b1;
        checks++;
        if (snap() !== e) begin
            errors++;
            $display("FAIL pre_entry got %s want %s", fmt(snap()), fmt(e));
        end
        n = 0;
        while (n < NTP) begin
            if ($urandom_range(31) == 0) step(1'b0);
            else begin
                step(1'b1);
                n++;
                e = play_exp(n);
                checks++;
                if (snap() !== e) begin
                    errors++;
                    $display("FAIL play n=%0d got %s want %s", n, fmt(snap()), fmt(e));
                end
            end
        end
`ifdef LOOP_PLAY_EN
        press(1'b0, 1'b1, 1'b0);
        checks++;
        if ({bus.busy, bus.prepacket, bus.mem_re, bus.rec_valid} !== 4'b0001) begin
            errors++;
            $display("FAIL loop_stop got busy=%0b pre=%0b re=%0b rv=%0b want 0 0 0 1",
                     bus.busy, bus.prepacket, bus.mem_re, bus.rec_valid);
        end
`else
        step(1'b0);
        e    = '0;
        e.rv = 1'b1;
        checks++;
        if (snap() !== e) begin
            errors++;
            $display("FAIL play_end got %s want %s", fmt(snap()), fmt(e));
        end
`endif
    endtask

    task automatic test_abort();
        int n;
        int target;
        press(1'b0, 1'b1, 1'b0);
        target = 32 + 500 * 32 + int'($urandom_range(29));
        n = 0;
        while (n < target) begin
            if ($urandom_range(31) == 0) step(1'b0);
            else begin
                step(1'b1);
                n++;
                e = play_exp(n);
                checks++;
                if (snap() !== e) begin
                    errors++;
                    $display("FAIL abort_play n=%0d got %s want %s", n, fmt(snap()), fmt(e));
                end
            end
        end
        // tick held high through the press: the press-cycle tick is dropped
        press(1'b1, 1'b0, 1'b1);
        e      = '0;
        e.busy = 1'b1;
        checks++;
        if (snap() !== e) begin
            errors++;
            $display("FAIL abort_rec got %s want %s", fmt(snap()), fmt(e));
        end
        for (int i = 1; i <= 32; i++) begin
            step(1'b1);
            e = rec_exp(i);
            checks++;
            if (snap() !== e) begin
                errors++;
                $display("FAIL abort_rec i=%0d got %s want %s", i, fmt(snap()), fmt(e));
            end
        end
        bus.bit_tick = 1'b1;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (snap() !== snap_t'('0)) begin
            errors++;
            $display("FAIL async_reset got %s want all 0", fmt(snap()));
        end
        @(negedge clk);
        reset = 1'b0;
        step(1'b1);
        checks++;
        if (snap() !== snap_t'('0)) begin
            errors++;
            $display("FAIL post_reset got %s want all 0", fmt(snap()));
        end
        press(1'b0, 1'b1, 1'b0);
        checks++;
        if (snap() !== snap_t'('0)) begin
            errors++;
            $display("FAIL play_after_reset got %s want all 0", fmt(snap()));
        end
    endtask

    initial begin
        test_reset();
        test_play_no_rec();
        test_simul_press();
        test_record();
        test_play();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
